// File: rtl/regfile_writeback_queue_pkg.sv
// Shared CPU definitions used by the writeback queue: register-file geometry
// and the {register, value} record carried through the queue.
package regfile_writeback_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // "reg" is a reserved word, so the destination register field is reg_num.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_num;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic wb_entry_t make_entry(input logic [REG_ADDR_W-1:0] r,
                                           input logic [DATA_W-1:0]     d);
    wb_entry_t e;
    e.reg_num = r;
    e.data    = d;
    return e;
  endfunction

endpackage

// File: rtl/regfile_writeback_queue_match.sv
// Youngest-match lookup over the occupied queue entries for one decode read port.
// Register 0 never hits because writes to it are never queued.
module wbq_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0]   entries_i,
  input  logic [AW-1:0]           rd_ptr_i,
  input  logic [CW-1:0]           count_i,
  input  logic [REG_ADDR_W-1:0]   rd_reg_i,
  output logic                    hit_o,
  output logic [DATA_W-1:0]       hit_data_o
);

  logic [DEPTH-1:0]  match_by_age;
  logic [DATA_W-1:0] data_by_age [DEPTH];

  // Slot gi holds the entry gi positions behind the head (0 = oldest).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [AW-1:0] idx;
    assign idx               = rd_ptr_i + AW'(gi);
    assign match_by_age[gi]  = (CW'(gi) < count_i) && (entries_i[idx].reg_num == rd_reg_i);
    assign data_by_age[gi]   = entries_i[idx].data;
  end

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    if (rd_reg_i != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (match_by_age[i]) begin
          hit_o      = 1'b1;
          hit_data_o = data_by_age[i];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// FIFO of pending register-file writes between writeback producers and the
// single regfile write port, with forwarding lookups for both decode read ports.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  output logic                  hit1,
  output logic                  hit2,
  output logic [DATA_W-1:0]     hit_data1,
  output logic [DATA_W-1:0]     hit_data2,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;
  wb_entry_t             head;

  assign in_ready = (count_q != CW'(DEPTH));
  assign wr_en    = (count_q != '0);
  assign count    = count_q;
  // Writes to r0 are accepted but dropped: r0 is hardwired in the regfile.
  assign push     = in_valid && in_ready && (in_reg != '0);
  assign pop      = wr_en;

  assign head    = mem_q[rd_ptr_q];
  assign wr_reg  = wr_en ? head.reg_num : '0;
  assign wr_data = wr_en ? head.data    : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked solely by pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= make_entry(in_reg, in_data);
  end

  logic [1:0][REG_ADDR_W-1:0] rd_regs;
  logic [1:0]                 hits;
  logic [1:0][DATA_W-1:0]     hit_datas;

  assign rd_regs[0] = rd_reg1;
  assign rd_regs[1] = rd_reg2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    wbq_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .CW    (CW)
    ) u_match (
      .entries_i  (mem_q),
      .rd_ptr_i   (rd_ptr_q),
      .count_i    (count_q),
      .rd_reg_i   (rd_regs[gi]),
      .hit_o      (hits[gi]),
      .hit_data_o (hit_datas[gi])
    );
  end

  assign hit1      = hits[0];
  assign hit2      = hits[1];
  assign hit_data1 = hit_datas[0];
  assign hit_data2 = hit_datas[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a vector table for single-cycle
// behaviour plus hand sequences for preloaded multi-entry and full-queue cases.
module tb_regfile_writeback_queue;
  import regfile_writeback_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg1, rd_reg2;
  logic        hit1, hit2;
  logic [31:0] hit_data1, hit_data2;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .hit1      (hit1),
    .hit2      (hit2),
    .hit_data1 (hit_data1),
    .hit_data2 (hit_data2),
    .count     (count)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  ireg;
    logic [31:0] idata;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        e_ready;
    logic        e_wr_en;
    logic [4:0]  e_wr_reg;
    logic [31:0] e_wr_data;
    int          e_count;
    logic        e_hit1;
    logic [31:0] e_hd1;
    logic        e_hit2;
    logic [31:0] e_hd2;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic r, logic v, logic [4:0] ir, logic [31:0] id,
                              logic [4:0] r1, logic [4:0] r2,
                              logic er, logic ee, logic [4:0] ewr, logic [31:0] ewd, int ec,
                              logic eh1, logic [31:0] ed1, logic eh2, logic [31:0] ed2);
    vec_t t;
    t.rst = r; t.vld = v; t.ireg = ir; t.idata = id; t.rd1 = r1; t.rd2 = r2;
    t.e_ready = er; t.e_wr_en = ee; t.e_wr_reg = ewr; t.e_wr_data = ewd; t.e_count = ec;
    t.e_hit1 = eh1; t.e_hd1 = ed1; t.e_hit2 = eh2; t.e_hd2 = ed2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t t);
    chk({tag, " in_ready"},  32'(in_ready),  32'(t.e_ready));
    chk({tag, " wr_en"},     32'(wr_en),     32'(t.e_wr_en));
    chk({tag, " wr_reg"},    32'(wr_reg),    32'(t.e_wr_reg));
    chk({tag, " wr_data"},   wr_data,        t.e_wr_data);
    chk({tag, " count"},     32'(count),     32'(t.e_count));
    chk({tag, " hit1"},      32'(hit1),      32'(t.e_hit1));
    chk({tag, " hit_data1"}, hit_data1,      t.e_hd1);
    chk({tag, " hit2"},      32'(hit2),      32'(t.e_hit2));
    chk({tag, " hit_data2"}, hit_data2,      t.e_hd2);
  endtask

  task automatic step(input vec_t t);
    rst = t.rst; in_valid = t.vld; in_reg = t.ireg; in_data = t.idata;
    rd_reg1 = t.rd1; rd_reg2 = t.rd2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; rd_reg1 = '0; rd_reg2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Backdoor preload: places entries directly so the bench can build
  // multi-entry and full states that the port protocol alone cannot reach.
  task automatic preload(input int n, input logic [4:0] regs [4], input logic [31:0] datas [4]);
    for (int i = 0; i < n; i++) dut.mem_q[i] = make_entry(regs[i], datas[i]);
    dut.rd_ptr_q = 2'd0;
    dut.wr_ptr_q = 2'(n);
    dut.count_q  = CW'(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  pr [4];
    logic [31:0] pd [4];
    logic [4:0]  exp_reg [5];
    logic [31:0] exp_data [5];
    int          widx;
    int          accepts;
    logic        accept_now;

    idle_inputs();

    //         rst vld reg    data           rd1 rd2 | rdy en wreg  wdata          cnt h1 hd1           h2 hd2
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 5, 0,   1, 1, 5, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        5, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h1234,     0, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h101,      0, 0,   1, 1, 1, 32'h101,      1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 2, 32'h102,      0, 1,   1, 1, 2, 32'h102,      1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 3, 32'h103,      3, 2,   1, 1, 3, 32'h103,      1, 1, 32'h103,      0, 32'h0));
    vecs.push_back(mk(0, 1, 4, 32'h104,      4, 0,   1, 1, 4, 32'h104,      1, 1, 32'h104,      0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        4, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 6, 32'h600,      0, 6,   1, 1, 6, 32'h600,      1, 0, 32'h0,        1, 32'h600));
    vecs.push_back(mk(1, 1, 7, 32'h700,      6, 7,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        7, 6,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      $display("vec %0d: rst=%0d vld=%0d reg=%0d data=0x%0h -> wr_en=%0d wr_reg=%0d wr_data=0x%0h count=%0d",
               i, vecs[i].rst, vecs[i].vld, vecs[i].ireg, vecs[i].idata, wr_en, wr_reg, wr_data, count);
      chk_all($sformatf("v%0d", i), vecs[i]);
    end

    // No combinational in_* -> wr_*/hit path: a request is invisible until accepted.
    idle_inputs();
    in_valid = 1'b1; in_reg = 5'd8; in_data = 32'h88; rd_reg1 = 5'd8;
    #1;
    chk("comb wr_en", 32'(wr_en), 32'd0);
    chk("comb hit1",  32'(hit1),  32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("latency: wr_en=%0d wr_reg=%0d hit1=%0d", wr_en, wr_reg, hit1);
    chk("latency wr_reg", 32'(wr_reg), 32'd8);
    chk("latency hit1",   32'(hit1),   32'd1);

    // Two pending writes to r3: forwarding returns the younger value.
    do_reset();
    pr = '{5'd3, 5'd3, 5'd0, 5'd0};
    pd = '{32'hA, 32'hB, 32'h0, 32'h0};
    #1;
    preload(2, pr, pd);
    rd_reg1 = 5'd3; rd_reg2 = 5'd4;
    #1;
    $display("fwd: hit1=%0d hd1=0x%0h hit2=%0d hd2=0x%0h count=%0d", hit1, hit_data1, hit2, hit_data2, count);
    chk("fwd hit1",      32'(hit1),  32'd1);
    chk("fwd hit_data1", hit_data1,  32'hB);
    chk("fwd hit2",      32'(hit2),  32'd0);
    chk("fwd hit_data2", hit_data2,  32'h0);
    chk("fwd head reg",  32'(wr_reg), 32'd3);
    chk("fwd head data", wr_data,    32'hA);
    rd_reg1 = 5'd0;
    #1;
    chk("fwd r0 hit1",      32'(hit1), 32'd0);
    chk("fwd r0 hit_data1", hit_data1, 32'h0);
    rd_reg1 = 5'd3;
    @(posedge clk); #1;
    chk("fwd after pop count", 32'(count), 32'd1);
    chk("fwd after pop data",  wr_data,    32'hB);
    chk("fwd after pop hd1",   hit_data1,  32'hB);
    @(posedge clk); #1;
    chk("fwd drained count", 32'(count), 32'd0);

    // Reset with two pending entries and a simultaneous request discards everything.
    do_reset();
    pr = '{5'd20, 5'd21, 5'd0, 5'd0};
    pd = '{32'h20, 32'h21, 32'h0, 32'h0};
    #1;
    preload(2, pr, pd);
    #1;
    chk("rst pre count", 32'(count), 32'd2);
    rst = 1'b1; in_valid = 1'b1; in_reg = 5'd22; in_data = 32'h22;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    $display("rst mid-op: count=%0d wr_en=%0d in_ready=%0d", count, wr_en, in_ready);
    chk("rst count",    32'(count),    32'd0);
    chk("rst wr_en",    32'(wr_en),    32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst no write c%0d", c), 32'(wr_en), 32'd0);
    end

    // Full queue: a held request waits for in_ready and is written exactly once, last.
    do_reset();
    pr = '{5'd10, 5'd11, 5'd12, 5'd13};
    pd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    #1;
    preload(4, pr, pd);
    in_valid = 1'b1; in_reg = 5'd14; in_data = 32'h77;
    #1;
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full count",    32'(count),    32'd4);
    exp_reg  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h77};
    widx = 0;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      if (wr_en) begin
        $display("full drain c%0d: wr_reg=%0d wr_data=0x%0h count=%0d", c, wr_reg, wr_data, count);
        if (widx < 5) begin
          chk($sformatf("full write%0d reg", widx),  32'(wr_reg), 32'(exp_reg[widx]));
          chk($sformatf("full write%0d data", widx), wr_data,     exp_data[widx]);
        end else begin
          chk("full extra write", 32'(wr_en), 32'd0);
        end
        widx++;
      end
      accept_now = in_valid && in_ready;
      @(posedge clk); #1;
      if (accept_now) begin
        accepts++;
        in_valid = 1'b0;
      end
    end
    chk("full writes total", 32'(widx),    32'd5);
    chk("full accepts",      32'(accepts), 32'd1);
    chk("full end count",    32'(count),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
REGFILE_WRITEBACK_QUEUE -- requirements
Module: regfile_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; a power of two from 2 to 16.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH+1), width of the count output.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  writeback request present.
REQ-006 in_ready  output  1  queue can accept a request this cycle.
REQ-007 in_reg  input  5  destination register number.
REQ-008 in_data  input  32  value to write.
REQ-009 wr_en  output  1  drives register file regWrite.
REQ-010 wr_reg  output  5  drives register file write_reg.
REQ-011 wr_data  output  32  drives register file write_value.
REQ-012 rd_reg1, rd_reg2  input  5 each  register numbers currently being read in decode.
REQ-013 hit1, hit2  output  1 each  a pending write exists for rd_reg1 / rd_reg2.
REQ-014 hit_data1, hit_data2  output  32 each  forwarded pending value; 0 when the matching hit is low.
REQ-015 count  output  CW  number of occupied entries.

Function
REQ-016 The block SHALL be a FIFO of {reg, data} entries between writeback producers and the register file write port.
REQ-017 A push SHALL occur on a posedge when in_valid and in_ready are both 1 and in_reg != 0.
REQ-018 A request with in_reg == 0 and in_ready == 1 SHALL be accepted and discarded, with no entry and no count change.
REQ-019 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on same-cycle pop.
REQ-020 wr_en SHALL equal (count != 0) combinationally, with wr_reg/wr_data taken from the head entry.
REQ-021 When wr_en is 0, wr_reg and wr_data SHALL be 0.
REQ-022 A pop SHALL occur on every posedge where wr_en == 1; the register file is always ready.
REQ-023 Latency: a request accepted at edge N SHALL appear on wr_* no earlier than the cycle after edge N; there is no in_* to wr_* combinational path.
REQ-024 Write order SHALL equal acceptance order.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; only a push raises count by 1; only a pop lowers it by 1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 hitK SHALL be 1 iff rd_regK != 0 and at least one occupied entry, the head included, has reg == rd_regK.
REQ-028 On multiple matches, hit_dataK SHALL return the data of the youngest matching entry.
REQ-029 The lookup SHALL NOT see same-cycle in_* requests.
REQ-030 Under full plus in_valid, the request SHALL be held off (in_ready 0) and no data lost; the producer must hold it stable.

Reset
REQ-031 On posedge clk with rst == 1, pointers and count SHALL go to 0, so outputs become: wr_en 0, wr_reg 0, wr_data 0, hit1/hit2 0, hit_data1/hit_data2 0, in_ready 1, count 0.
REQ-032 Reset during operation SHALL discard all pending entries, with no wr_en pulse in the reset cycle's following cycle.
REQ-033 rst SHALL take priority over a simultaneous push or pop.
REQ-034 Entry data storage need not be cleared; valid tracking is by count and pointers only.

Structure
REQ-035 The shared CPU package SHALL hold REG_ADDR_W = 5, DATA_W = 32 and typedef wb_entry_t {reg, data}.
REQ-036 The block SHALL have one sub-module, wbq_match, that performs youngest-match selection, instantiated once per read port.

Verification
REQ-037 Reset then push {5, 0xDEADBEEF} -> next cycle: wr_en 1, wr_reg 5, wr_data 0xDEADBEEF, count 1; cycle after that: wr_en 0, count 0.
REQ-038 Push in_reg 0 with data 0x1234 -> in_ready 1, count stays 0, wr_en stays 0.
REQ-039 DEPTH 4, push every cycle from empty -> after the steady state push+pop, count holds 1 and wr_* shows 1,2,3... in order with no drops.
REQ-040 Preload {3, 0xA} and {3, 0xB}, rd_reg1 3, rd_reg2 4 -> hit1 1, hit_data1 0xB, hit2 0, hit_data2 0; rd_reg1 0 -> hit1 0.
REQ-041 Count 2, then rst for one cycle with in_valid 1 -> count 0, wr_en 0 the next cycle, in_ready 1, and no later writes of the old entries.
REQ-042 Force full by holding pop (bench-only: DEPTH entries pushed at one edge) -> in_ready 0, and in_valid with data 0x77 is held until in_ready rises, then written once.
